// File: rtl/tx_client_arbiter.sv
// Round-robin arbiter sharing one Tx port among NCLI clients: latches the winner's
// length, routes ack/strobe/warn to the winner only, and muxes its data byte.
module tx_client_arbiter #(
    parameter int NCLI     = 3,
    parameter int jumbo_dw = 14,
    parameter int GAP      = 4,
    parameter int TMO_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCLI-1:0]          req,
    input  logic [NCLI*jumbo_dw-1:0] length,
    input  logic [NCLI*8-1:0]        data_in,
    output logic [NCLI-1:0]          ack,
    output logic [NCLI-1:0]          strobe,
    output logic [NCLI-1:0]          warn,
    output logic                     req_m,
    output logic [jumbo_dw-1:0]      length_m,
    output logic [7:0]               data_m,
    input  logic                     ack_m,
    input  logic                     strobe_m,
    input  logic                     warn_m,
    output logic [NCLI-1:0]          active,
    output logic [7:0]               timeouts
);
    localparam int PW = $clog2(NCLI);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, HOLD} state_t;

    state_t               state_reg;
    logic [PW-1:0]        ptr_reg;
    logic [PW-1:0]        win_reg;
    logic [NCLI-1:0]      active_reg;
    logic                 req_m_reg;
    logic [jumbo_dw-1:0]  length_m_reg;
    logic [jumbo_dw-1:0]  bcnt_reg;
    logic [TMO_W-1:0]     wd_reg;
    logic [GW-1:0]        gcnt_reg;
    logic [7:0]           timeouts_reg;

    logic [jumbo_dw-1:0]  len_arr [NCLI];
    logic [7:0]           dat_arr [NCLI];

    logic                 found;
    logic [PW-1:0]        win_next;
    logic [PW:0]          sum;
    logic [PW-1:0]        ptr_next;
    logic [jumbo_dw-1:0]  last_byte;
    logic [TMO_W-1:0]     wd_inc;
    logic                 timeout;
    logic                 done;
    logic                 in_grant;
    logic                 in_busy;

    assign in_grant = (state_reg == GRANT);
    assign in_busy  = (state_reg == BUSY);

    // Strobes are only meaningful once the Tx port has accepted, so in GRANT
    // they are forwarded only on the ack_m cycle (where they count as byte 0).
    for (genvar gi = 0; gi < NCLI; gi++) begin : g_cli
        assign len_arr[gi] = length[gi*jumbo_dw +: jumbo_dw];
        assign dat_arr[gi] = data_in[gi*8 +: 8];
        assign ack[gi]     = active_reg[gi] & ack_m & in_grant;
        assign strobe[gi]  = active_reg[gi] & strobe_m & (in_busy | (in_grant & ack_m));
        assign warn[gi]    = active_reg[gi] & warn_m & (in_busy | in_grant);
    end

    always_comb begin
        found    = 1'b0;
        win_next = '0;
        sum      = '0;
        for (int k = 0; k < NCLI; k++) begin
            sum = {1'b0, ptr_reg} + (PW+1)'(k);
            if (sum >= (PW+1)'(NCLI))
                sum = sum - (PW+1)'(NCLI);
            if (!found && req[sum[PW-1:0]]) begin
                found    = 1'b1;
                win_next = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        data_m = '0;
        for (int i = 0; i < NCLI; i++)
            if (active_reg[i])
                data_m = data_m | dat_arr[i];
    end

    assign ptr_next  = (win_reg == PW'(NCLI-1)) ? '0 : win_reg + 1'b1;
    assign last_byte = (length_m_reg == '0) ? '0 : length_m_reg - 1'b1;
    assign wd_inc    = wd_reg + 1'b1;
    assign timeout   = in_busy & ~strobe_m & (wd_inc == '1);
    assign done      = (in_grant & ack_m & strobe_m & (last_byte == '0))
                     | (in_busy & strobe_m & (bcnt_reg == last_byte))
                     | timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            win_reg      <= '0;
            active_reg   <= '0;
            req_m_reg    <= 1'b0;
            length_m_reg <= '0;
            bcnt_reg     <= '0;
            wd_reg       <= '0;
            gcnt_reg     <= '0;
            timeouts_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        win_reg      <= win_next;
                        active_reg   <= {{(NCLI-1){1'b0}}, 1'b1} << win_next;
                        length_m_reg <= len_arr[win_next];
                        req_m_reg    <= 1'b1;
                        state_reg    <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack_m) begin
                        req_m_reg <= 1'b0;
                        wd_reg    <= '0;
                        bcnt_reg  <= strobe_m ? jumbo_dw'(1) : '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (strobe_m) begin
                        wd_reg   <= '0;
                        bcnt_reg <= bcnt_reg + 1'b1;
                    end else begin
                        wd_reg <= wd_inc;
                        if (timeout && timeouts_reg != 8'hFF)
                            timeouts_reg <= timeouts_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (gcnt_reg == GW'(GAP-1)) begin
                        gcnt_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        gcnt_reg <= gcnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // Completion or watchdog abort overrides the per-state updates above.
            if (done) begin
                state_reg  <= HOLD;
                active_reg <= '0;
                ptr_reg    <= ptr_next;
                gcnt_reg   <= '0;
            end
        end
    end

    assign req_m    = req_m_reg;
    assign length_m = length_m_reg;
    assign active   = active_reg;
    assign timeouts = timeouts_reg;

endmodule

// File: tb/tb_tx_client_arbiter.sv
// Directed bench for tx_client_arbiter: a cycle table for basic grant/forwarding,
// then hand sequences for round robin, wrap, watchdog and mid-packet reset.
module tb_tx_client_arbiter;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [41:0] length;
    logic [23:0] data_in;
    logic [2:0]  ack, strobe, warn, active;
    logic        req_m, ack_m, strobe_m, warn_m;
    logic [13:0] length_m;
    logic [7:0]  data_m, timeouts;

    logic [13:0] len_v [3];
    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit have_last = 0;

    assign length  = {len_v[2], len_v[1], len_v[0]};
    assign data_in = {8'hA2, 8'hA1, 8'hA0};

    tx_client_arbiter #(.NCLI(3), .jumbo_dw(14), .GAP(GAP), .TMO_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .length(length), .data_in(data_in),
        .ack(ack), .strobe(strobe), .warn(warn), .req_m(req_m), .length_m(length_m),
        .data_m(data_m), .ack_m(ack_m), .strobe_m(strobe_m), .warn_m(warn_m),
        .active(active), .timeouts(timeouts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  req;
        logic        ackm, strb, wrn;
        logic [2:0]  e_ack, e_str, e_wrn, e_act;
        logic        e_reqm;
        logic [13:0] e_len;
    } vec_t;
    vec_t tv [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else
            $display("ok   %s: %0h", name, act);
    endtask

    function automatic logic [7:0] exp_data(input logic [2:0] a);
        case (a)
            3'b001:  return 8'hA0;
            3'b010:  return 8'hA1;
            3'b100:  return 8'hA2;
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; ack_m = 1'b0; strobe_m = 1'b0; warn_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", 64'({ack, strobe, warn, active, req_m, length_m, data_m, timeouts}), 64'd0);
        rst = 1'b0;
        have_last = 0;
    endtask

    task automatic wait_req_m(input string name);
        int n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!req_m && n < 60);
        chk({name, "_req_m_seen"}, 64'(req_m), 64'd1);
    endtask

    // Drive one full packet for expected winner w; ack_m after ack_dly cycles.
    task automatic run_packet(input int w, input int ack_dly, input bit coinc, input logic [2:0] req_after);
        logic [2:0]  oh;
        logic [13:0] ln;
        int nb;
        string tag;
        oh = 3'b001 << w;
        ln = len_v[w];
        nb = (ln == 0) ? 1 : int'(ln);
        tag = $sformatf("pkt_c%0d", w);
        ack_m = 1'b0; strobe_m = 1'b0;
        wait_req_m(tag);
        if (have_last)
            chk({tag, "_gap"}, 64'(cyc - last_cyc), 64'(GAP + 2));
        chk({tag, "_active"}, 64'(active), 64'(oh));
        chk({tag, "_length_m"}, 64'(length_m), 64'(ln));
        chk({tag, "_data_m"}, 64'(data_m), 64'(exp_data(oh)));
        for (int d = 0; d <= ack_dly; d++) begin
            if (d > 0) @(negedge clk);
            ack_m = (d == ack_dly);
            strobe_m = coinc && (d == ack_dly);
            #1;
            chk({tag, "_ack"}, 64'({ack, req_m}), 64'({(d == ack_dly) ? oh : 3'b000, 1'b1}));
        end
        if (coinc) begin
            chk({tag, "_strobe_on_ack"}, 64'(strobe), 64'(oh));
            last_cyc = cyc;
        end
        for (int b = coinc ? 1 : 0; b < nb; b++) begin
            @(negedge clk);
            ack_m = 1'b0; strobe_m = 1'b1; req = req_after;
            #1;
            chk($sformatf("%s_strobe_b%0d", tag, b), 64'({strobe, data_m}), 64'({oh, exp_data(oh)}));
            last_cyc = cyc;
        end
        @(negedge clk);
        ack_m = 1'b0; strobe_m = 1'b0; req = req_after;
        #1;
        chk({tag, "_done_hold"}, 64'({active, strobe}), 64'd0);
        have_last = 1;
    endtask

    initial begin
        rst = 1'b1; req = '0; ack_m = 1'b0; strobe_m = 1'b0; warn_m = 1'b0;
        len_v[0] = 14'd2; len_v[1] = 14'd1; len_v[2] = 14'd0;

        //           req    ackm  strb  wrn   e_ack   e_str   e_wrn   e_act   reqm  len
        tv[0]  = '{3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd0};
        tv[1]  = '{3'b010, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b010, 3'b010, 1'b1, 14'd1};
        tv[2]  = '{3'b010, 1'b1, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 3'b010, 1'b1, 14'd1};
        tv[3]  = '{3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd1};
        tv[4]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd1};
        tv[5]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd1};
        tv[6]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd1};
        tv[7]  = '{3'b101, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd1};
        tv[8]  = '{3'b101, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b1, 14'd0};
        tv[9]  = '{3'b001, 1'b1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 3'b100, 1'b1, 14'd0};
        tv[10] = '{3'b001, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 3'b000, 3'b100, 1'b0, 14'd0};
        tv[11] = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd0};
        tv[12] = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd0};
        tv[13] = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd0};
        tv[14] = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd0};
        tv[15] = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd0};
        tv[16] = '{3'b001, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 14'd2};
        tv[17] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 3'b000, 3'b001, 1'b0, 14'd2};
        tv[18] = '{3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 14'd2};
        tv[19] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 3'b000, 3'b001, 1'b0, 14'd2};
        tv[20] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 14'd2};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            req = tv[i].req; ack_m = tv[i].ackm; strobe_m = tv[i].strb; warn_m = tv[i].wrn;
            #1;
            chk($sformatf("vec%0d", i),
                64'({ack, strobe, warn, active, req_m, length_m, data_m}),
                64'({tv[i].e_ack, tv[i].e_str, tv[i].e_wrn, tv[i].e_act, tv[i].e_reqm,
                     tv[i].e_len, exp_data(tv[i].e_act)}));
        end
        warn_m = 1'b0;

        // Single client, long packet, late ack_m.
        do_reset();
        len_v[1] = 14'd60;
        req = 3'b010;
        run_packet(1, 3, 1'b0, 3'b000);

        // All clients requesting: strict rotation and fixed inter-packet spacing.
        do_reset();
        len_v[0] = 14'd8; len_v[1] = 14'd8; len_v[2] = 14'd8;
        req = 3'b111;
        for (int p = 0; p < 6; p++)
            run_packet(p % 3, 0, 1'b0, 3'b111);

        // Client 2 alone, client 0 joins mid-packet; pointer wraps 2 -> 0.
        do_reset();
        len_v[2] = 14'd5; len_v[0] = 14'd4;
        req = 3'b100;
        run_packet(2, 1, 1'b0, 3'b101);
        run_packet(0, 0, 1'b0, 3'b000);

        // Coincident strobe with ack_m on a 1-byte packet.
        len_v[1] = 14'd1;
        req = 3'b010;
        have_last = 0;
        run_packet(1, 0, 1'b1, 3'b000);

        // Watchdog: no strobes after ack_m.
        do_reset();
        len_v[1] = 14'd10; len_v[2] = 14'd3;
        req = 3'b010;
        wait_req_m("wd");
        chk("wd_active", 64'(active), 64'(3'b010));
        ack_m = 1'b1;
        begin
            int busy = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                ack_m = 1'b0; req = 3'b101;
                #1;
                if (active == 3'b000) break;
                busy++;
            end
            chk("wd_busy_cycles", 64'(busy), 64'd15);
            chk("wd_timeouts", 64'(timeouts), 64'd1);
        end
        run_packet(2, 0, 1'b0, 3'b000);

        // Reset in the middle of a packet, with ptr != 0 beforehand.
        len_v[0] = 14'd2;
        req = 3'b001;
        run_packet(0, 0, 1'b0, 3'b000);
        len_v[1] = 14'd64;
        req = 3'b010;
        wait_req_m("mid");
        chk("mid_active", 64'(active), 64'(3'b010));
        ack_m = 1'b1;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            ack_m = 1'b0; req = 3'b000; strobe_m = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_outputs", 64'({req_m, active, ack, strobe, length_m, timeouts}), 64'd0);
        rst = 1'b0; strobe_m = 1'b0;
        req = 3'b111;
        have_last = 0;
        run_packet(0, 0, 1'b0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
